// File: rtl/bk_serial_add_ctrl.sv
// bk_serial_add_ctrl -- multi-cycle wide adder sequencer.
//
// One SLICE_W-bit adder slice is reused for NUM_SLICES cycles. Slices are
// processed least-significant first, and the carry between slices is held in
// a register. There is a valid/ready handshake on both the operand side and
// the result side.
//
// Optional feature: define BKSEQ_SUB_EN to add the `sub` input. With sub=1 the
// block computes A + ~B + 1; Cin is ignored and Cout=1 means no borrow.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous reset, active low
//   in_valid   in   1  operand request
//   in_ready   out  1  operands accepted (high only in IDLE)
//   A, B       in   W  operands, sampled on accept
//   Cin        in   1  carry-in, sampled on accept
//   sub        in   1  (BKSEQ_SUB_EN only) subtract, sampled on accept
//   out_valid  out  1  Sum/Cout hold a finished result
//   out_ready  in   1  consumer takes the result
//   Sum        out  W  registered sum
//   Cout       out  1  registered carry-out of the top slice
module bk_serial_add_ctrl #(
  parameter int SLICE_W    = 16,
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] A,
  input  logic [SLICE_W*NUM_SLICES-1:0] B,
  input  logic                          Cin,
`ifdef BKSEQ_SUB_EN
  input  logic                          sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] Sum,
  output logic                          Cout
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_reg, b_reg;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   slice_sum;
  logic               accept;
  logic               last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Slice select feeding the shared adder
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_reg[i*SLICE_W +: SLICE_W];
        b_sl = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry};
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= A;
            idx   <= '0;
            Sum   <= '0;
`ifdef BKSEQ_SUB_EN
            // Subtraction is folded in at capture: store ~B, force carry-in to 1.
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
`else
            b_reg <= B;
            carry <= Cin;
`endif
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NUM_SLICES; i++) begin
            if (idx == IDX_W'(i)) Sum[i*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
          end
          carry <= slice_sum[SLICE_W];
          if (last) begin
            Cout <= slice_sum[SLICE_W];
            idx  <= '0;
          end else begin
            idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_serial_add_ctrl.sv
// Directed bench for bk_serial_add_ctrl (default 4 x 16-bit slices).
// Define BKSEQ_SUB_EN for both files to also exercise subtraction.
module tb_bk_serial_add_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
`ifdef BKSEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bk_serial_add_ctrl #(.SLICE_W(16), .NUM_SLICES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef BKSEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, then release it.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic [W:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, {64'd0, in_ready}, 65'd1);
    A = a; B = b; Cin = c;
`ifdef BKSEQ_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub requested without BKSEQ_SUB_EN");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_lat"}, 65'(n), 65'd4);
    check({tag, "_res"}, {Cout, Sum}, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W:0] q[$];
    logic [W:0] e;
    int         last_ov;
    int         n;

    // Reset state
    #2;
    check("rst_sum", {Cout, Sum}, 65'd0);
    check("rst_ov", {64'd0, out_valid}, 65'd0);
    #10 rst_n = 1'b1;
    tick();
    check("rel_ready", {64'd0, in_ready}, 65'd1);

    // 1: full carry ripple
    do_op("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 64'd0});
    // 2: carry stops in slice 1
    do_op("t2", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 1'b0, {1'b0, 64'h0000_FFFF_0001_0001});
    // plain patterns
    do_op("t2b", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
          {1'b0, 64'h2345_6789_ABCD_F001});
    do_op("t2c", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
          {1'b1, 64'd1});

    // 3: result held while out_ready=0; in_valid ignored
    A = 64'd10; B = 64'd20; Cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("t3_lat", 65'(n), 65'd4);
    A = 64'd7; B = 64'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {Cout, Sum}, 65'd30);
      check("t3_ov", {63'd0, out_valid, in_ready}, 65'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_idle", {63'd0, out_valid, in_ready}, 65'b01);
    for (int i = 0; i < 6; i++) tick();
    check("t3_nocap", {63'd0, out_valid, in_ready}, 65'b01);
    check("t3_sum", {Cout, Sum}, 65'd30);

    // 4: reset mid-operation (idx=2), partial Sum is nonzero at that point
    A = 64'h0001_0001_0001_0001; B = 64'h0002_0002_0002_0002; Cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_partial", {Cout, Sum}, {1'b0, 64'h0000_0000_0003_0003});
    rst_n = 1'b0;
    #1;
    check("t4_rst", {Cout, Sum}, 65'd0);
    check("t4_ov", {64'd0, out_valid}, 65'd0);
    #3 rst_n = 1'b1;
    tick();
    check("t4_ready", {64'd0, in_ready}, 65'd1);
    do_op("t4_op", 64'd3, 64'd4, 1'b0, 1'b0, 65'd7);

    // 5: back-to-back with in_valid/out_ready tied high
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_ov = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      automatic logic acc = in_ready;
      if (acc) q.push_back({1'b0, A} + {1'b0, B} + {64'd0, Cin});
      tick();
      if (out_valid) begin
        if (q.size() == 0) begin
          check("t5_spurious", 65'd1, 65'd0);
        end else begin
          e = q.pop_front();
          check("t5_res", {Cout, Sum}, e);
        end
        if (last_ov >= 0) check("t5_interval", 65'(cyc - last_ov), 65'd6);
        last_ov = cyc;
      end
      if (acc) begin
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'($urandom);
      end
    end
    check("t5_seen", 65'(last_ov > 0), 65'd1);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    out_ready = 1'b0;

`ifdef BKSEQ_SUB_EN
    // 6: subtraction
    do_op("t6a", 64'd5, 64'd7, 1'b1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    do_op("t6b", 64'd7, 64'd5, 1'b0, 1'b1, {1'b1, 64'd2});
    do_op("t6c", 64'd7, 64'd5, 1'b1, 1'b0, 65'd13);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
